// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add sequencer feeding a WIDTH-bit adder, LS word first.
//   clk, rst_n               : clock, asynchronous active-low reset
//   start, nwords, cin0      : launch an N-word add (sampled in IDLE only), busy while not IDLE
//   in_valid/in_ready/in_x/in_y : operand word-pair stream
//   x, y, cin / sm           : to adder / combinational sum (bit WIDTH is carry-out) from adder
//   out_valid/out_ready/out_data/out_last : result word stream, out_last on MS word
//   done, carry_out, zero_out: end-of-operation pulse and held final carry / all-zero flag
module mp_add_seq #(
  parameter int WIDTH  = 32,
  parameter int SWIDTH = WIDTH + 1,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNTW-1:0]   nwords,
  input  logic              cin0,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_y,
  output logic [WIDTH-1:0]  x,
  output logic [WIDTH-1:0]  y,
  output logic              cin,
  input  logic [SWIDTH-1:0] sm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              done,
  output logic              carry_out,
  output logic              zero_out
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2;
  logic [1:0] state;
  logic [CNTW-1:0] cnt;
  logic carry, zacc, acc, pop;
  assign busy = state != IDLE;
  // single-entry output register: a pop frees the slot in the same cycle
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign x = in_x;
  assign y = in_y;
  assign cin = carry;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      zacc      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && nwords != '0) begin
          state     <= RUN;
          cnt       <= nwords;
          carry     <= cin0;
          zacc      <= 1'b1;
          carry_out <= 1'b0;
          zero_out  <= 1'b0;
        end
      end else if (state == RUN) begin
        if (acc) begin
          out_data  <= sm[WIDTH-1:0];
          carry     <= sm[WIDTH];
          zacc      <= zacc && (sm[WIDTH-1:0] == '0);
          out_valid <= 1'b1;
          out_last  <= cnt == CNTW'(1);
          cnt       <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) state <= FLUSH;
        end else if (pop) out_valid <= 1'b0;
      end else if (pop) begin
        out_valid <= 1'b0;
        done      <= 1'b1;
        carry_out <= carry;
        zero_out  <= zacc && !carry;
        state     <= IDLE;
      end
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: scoreboard bench for mp_add_seq with a behavioural adder in the loop.
module tb_mp_add_seq;
  localparam int W = 32;
  localparam int C = 8;
  logic clk = 0, rst_n = 0, start = 0, cin0 = 0, in_valid = 0, out_ready = 1;
  logic [C-1:0] nwords = '0;
  logic [W-1:0] in_x = '0, in_y = '0;
  logic busy, in_ready, cin, out_valid, out_last, done, carry_out, zero_out;
  logic [W-1:0] x, y, out_data;
  logic [W:0] sm;
  int n_chk = 0, n_pass = 0, ndone = 0, left = 0;
  logic mc = 0, mz = 1;
  logic [W:0] q[$];
  logic [W-1:0] xa[8], ya[8];

  mp_add_seq #(.WIDTH(W), .SWIDTH(W + 1), .CNTW(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nwords(nwords), .cin0(cin0), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .x(x), .y(y), .cin(cin), .sm(sm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .carry_out(carry_out), .zero_out(zero_out)
  );

  assign sm = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // inputs change #1 after posedge, so negedge sees the handshakes the next edge will take
  always @(negedge clk) begin
    logic [W:0] s, e;
    if (!rst_n) begin
      q.delete();
      mc = 0;
      mz = 1;
    end else begin
      if (done) ndone++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_data", out_data, e[W-1:0]);
          chk("out_last", out_last, e[W]);
        end
      end
      if (in_valid && in_ready) begin
        s = {1'b0, in_x} + {1'b0, in_y} + {{W{1'b0}}, mc};
        mz = mz && (s[W-1:0] == 0);
        mc = s[W];
        q.push_back({left == 1, s[W-1:0]});
        left--;
      end
      if (start && !busy && nwords != 0) begin
        mc = cin0;
        mz = 1;
        left = nwords;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    bit ok = 0;
    in_valid = 1;
    in_x = a;
    in_y = b;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      t++;
    end
    in_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
    else chk("latency", out_valid, 1);
  endtask

  task automatic feed(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 3) repeat ($urandom_range(0, 1)) tick();
      if (mode == 2 && i == 0) begin
        start = 1;
        nwords = 9;
        cin0 = 1;
      end
      put(xa[i], ya[i]);
      start = 0;
    end
  endtask

  task automatic stall();
    int t = 0;
    logic [W-1:0] d;
    while (!out_valid && t < 100) begin
      tick();
      t++;
    end
    if (!out_valid) chk("stall_timeout", 0, 1);
    d = out_data;
    repeat (4) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_data, d);
    end
    out_ready = 1;
  endtask

  // mode: 0 plain, 1 backpressure, 2 start during RUN, 3 random gaps and out_ready
  task automatic op(input int n, input bit c0, input int ec, input int ez, input int mode);
    int d0 = ndone, t = 0;
    tick();
    start = 1;
    nwords = C'(n);
    cin0 = c0;
    tick();
    start = 0;
    chk("busy_run", busy, 1);
    if (mode == 1) out_ready = 0;
    fork
      feed(n, mode);
      begin
        if (mode == 1) stall();
        else if (mode == 3) begin
          repeat (n * 4) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
          end
          out_ready = 1;
        end
      end
    join
    out_ready = 1;
    while (ndone == d0 && t < 200) begin
      tick();
      t++;
    end
    chk("carry_out", carry_out, ec < 0 ? mc : ec[0]);
    chk("zero_out", zero_out, ez < 0 ? (mz && !mc) : ez[0]);
    repeat (3) tick();
    chk("done_once", ndone - d0, 1);
    chk("busy_idle", busy, 0);
    chk("sb_drained", q.size(), 0);
    chk("carry_hold", carry_out, ec < 0 ? mc : ec[0]);
  endtask

  initial begin
    int d0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cin", cin, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_zero", zero_out, 0);
    rst_n = 1;
    tick();
    xa[0] = 32'h5; ya[0] = 32'h3;
    op(1, 0, 0, 0, 0);
    xa[0] = 32'hFFFF_FFFF; ya[0] = 32'hFFFF_FFFF; xa[1] = 0; ya[1] = 0;
    op(2, 0, 0, 0, 0);
    xa[0] = 32'hFFFF_FFFF; ya[0] = 0; xa[1] = 32'hFFFF_FFFF; ya[1] = 0;
    op(2, 1, 1, 0, 0);
    xa[0] = 0; ya[0] = 0; xa[1] = 0; ya[1] = 0;
    op(2, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      xa[i] = $urandom;
      ya[i] = $urandom;
    end
    op(3, 0, -1, -1, 1);
    start = 1;
    nwords = 0;
    tick();
    start = 0;
    chk("zero_start_busy", busy, 0);
    repeat (2) tick();
    chk("zero_start_idle", busy, 0);
    op(3, 1, -1, -1, 2);
    op(6, 0, -1, -1, 3);
    d0 = ndone;
    tick();
    start = 1;
    nwords = 4;
    cin0 = 0;
    tick();
    start = 0;
    put(32'h1234, 32'h4321);
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_cin", cin, 0);
    repeat (2) tick();
    rst_n = 1;
    repeat (3) tick();
    chk("abort_no_done", ndone - d0, 0);
    chk("abort_idle", busy, 0);
    xa[0] = 32'h8000_0000; ya[0] = 32'h8000_0000;
    op(1, 0, 1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add sequencer directly upstream of the WIDTH-bit adder stage.
- Accepts a stream of operand word pairs, least-significant word first, and drives the adder's x, y, cin.
- Takes the adder's combinational SWIDTH-bit sum back, registers the low WIDTH bits as an output word stream and chains bit WIDTH as carry into the next word.
- Reports the final carry and an all-zero flag for the whole N-word sum.

Parameters:
- WIDTH, 32, word width; matches adder WIDTH.
- SWIDTH, WIDTH+1, adder sum width; sum bit WIDTH is carry-out.
- CNTW, 8, width of the word-count field; max operand length 2^CNTW-1 words.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- nwords  in  CNTW  number of word pairs; sampled with start.
- cin0  in  1  carry into least-significant word; sampled with start.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid && in_ready.
- in_x  in  WIDTH  operand A word.
- in_y  in  WIDTH  operand B word.
- x  out  WIDTH  to adder; equals in_x (combinational).
- y  out  WIDTH  to adder; equals in_y (combinational).
- cin  out  1  to adder; current chained carry register.
- sm  in  SWIDTH  combinational sum from adder.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts result word.
- out_data  out  WIDTH  result word.
- out_last  out  1  marks the most-significant result word.
- done  out  1  one-cycle pulse when the final word is consumed.
- carry_out  out  1  final carry; valid from done, held until next start.
- zero_out  out  1  1 iff all result words are 0 and final carry is 0; held like carry_out.

Behaviour:
- Reset: state IDLE. busy, in_ready, cin, out_valid, out_data, out_last, done, carry_out and zero_out are all 0. Word counter is 0.
- States:
  - IDLE: on start && nwords!=0, latch cnt=nwords, carry=cin0, zacc=1, clear carry_out/zero_out, go to RUN. start with nwords==0 is ignored and the block stays IDLE. start in any other state is ignored.
  - RUN: in_ready = !out_valid || out_ready (single-entry output register with pass-through on pop). On accept:
    - out_data <= sm[WIDTH-1:0]
    - carry <= sm[WIDTH]
    - zacc <= zacc && (sm[WIDTH-1:0]==0)
    - out_valid <= 1
    - out_last <= (cnt==1)
    - cnt <= cnt-1
    - When cnt==1, go to FLUSH.
  - FLUSH: in_ready=0. When out_valid && out_ready: out_valid<=0, done<=1 for one cycle, carry_out<=carry, zero_out<=zacc && !carry, go to IDLE.
- Latency: accepted operand pair to out_valid is 1 cycle. With out_ready held high, throughput is 1 word per cycle.
- Output hold: out_data and out_last stay stable while out_valid && !out_ready.
- In RUN, when a pop and a new accept happen in the same cycle, out_valid remains 1 and the data is replaced.
- in_valid is ignored when in_ready=0.
- Adder interface: cin is registered, so it is stable for the whole cycle. sm must be settled combinationally in the same cycle as in_x/in_y.
- Mid-operation reset: rst_n low aborts immediately. All outputs return to reset values and no done pulse is produced.
- Sum width: each result word is sm modulo 2^WIDTH. Only the final carry is exported.

Test Plan:
- Single word: start, nwords=1, cin0=0; x=0x0000_0005, y=0x0000_0003 → out_data=0x0000_0008, out_last=1, then done pulse; carry_out=0, zero_out=0.
- Carry chain: nwords=2, cin0=0; words {0xFFFF_FFFF,0xFFFF_FFFF} then {0x0000_0000,0x0000_0000} → out {0xFFFF_FFFE, 0x0000_0001}; carry_out=0.
- Final carry and zero flag: nwords=2, cin0=1; x words {0xFFFF_FFFF,0xFFFF_FFFF}, y words {0,0} → out {0,0}; carry_out=1, zero_out=0. Repeat with x={0,0}, y={0,0}, cin0=0 → zero_out=1.
- Backpressure: nwords=3, out_ready held low 4 cycles after first out_valid → in_ready=0, out_data stable. Release → remaining 2 words each follow 1 cycle after accept; done exactly once.
- Ignored starts: start with nwords=0 → busy stays 0. Start asserted during RUN → no effect on cnt or results.
- Reset mid-operation: assert rst_n low after 1 of 4 words → busy=0, out_valid=0, no done. A new start with nwords=1 completes correctly.
